// File: rtl/drum_pad_debouncer_pkg.sv
// Shared constants, types and helpers for the drum pad front end.
package drum_pkg;

  localparam int N_PADS_DEF = 16;

  typedef logic [N_PADS_DEF-1:0] pad_vec_t;

  // Width needed to hold values 0..v-1; never less than 1 bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/drum_pad_debounce_cell.sv
// One pad: 2-FF synchroniser, tick-sampled debounce counter, stable level and press pulse.
module drum_pad_debounce_cell
  import drum_pkg::*;
#(
  parameter int STABLE_TICKS   = 8,
  parameter bit PAD_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pad_raw,
  input  logic tick,
  output logic pad_state,
  output logic rise
);

  localparam int            CW      = clog2(STABLE_TICKS);
  localparam logic          REL_LVL = PAD_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_TICKS - 1);

  logic [1:0]    sync;
  logic          samp;
  logic [CW-1:0] cnt;
  logic          accept;

  // Both stages start at the released level so reset release cannot look like a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync <= {2{REL_LVL}};
    else          sync <= {sync[0], pad_raw};
  end

  assign samp   = sync[1] ^ REL_LVL;
  assign accept = tick && (samp != pad_state) && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      pad_state <= 1'b0;
    end else if (tick) begin
      if (samp == pad_state) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt       <= '0;
        pad_state <= samp;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Asserted on the cycle whose clock edge commits pad_state 0->1.
  assign rise = accept & samp;

endmodule

// File: rtl/drum_pad_debouncer.sv
// 16-pad debouncer with sticky press events for a Nios PIO, software clear and irq.
module drum_pad_debouncer
  import drum_pkg::*;
#(
  parameter int N_PADS         = N_PADS_DEF,
  parameter int CLK_HZ         = 50000000,
  parameter int TICK_HZ        = 1000,
  parameter int STABLE_TICKS   = 8,
  parameter bit PAD_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_PADS-1:0] pad_raw,
  input  logic [N_PADS-1:0] clear_mask,
  output logic [N_PADS-1:0] pad_state,
  output logic [N_PADS-1:0] pad_event,
  output logic              irq
);

  localparam int            DIV    = CLK_HZ / TICK_HZ;
  localparam int            PW     = clog2(DIV);
  localparam logic [PW-1:0] DIV_M1 = PW'(DIV - 1);

  logic [PW-1:0]     presc;
  logic              tick;
  logic [N_PADS-1:0] rise;
  logic [N_PADS-1:0] clear_mask_q;
  logic [N_PADS-1:0] clr;
  logic [N_PADS-1:0] event_next;

  assign tick = (presc == DIV_M1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  for (genvar g = 0; g < N_PADS; g++) begin : g_pad
    drum_pad_debounce_cell #(
      .STABLE_TICKS  (STABLE_TICKS),
      .PAD_ACTIVE_LOW(PAD_ACTIVE_LOW)
    ) u_cell (
      .clk      (clk),
      .reset_n  (reset_n),
      .pad_raw  (pad_raw[g]),
      .tick     (tick),
      .pad_state(pad_state[g]),
      .rise     (rise[g])
    );
  end

  // A press landing on the same cycle as a clear wins so it is never lost.
  assign clr        = clear_mask & ~clear_mask_q;
  assign event_next = rise | (pad_event & ~clr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clear_mask_q <= '0;
      pad_event    <= '0;
      irq          <= 1'b0;
    end else begin
      clear_mask_q <= clear_mask;
      pad_event    <= event_next;
      irq          <= |event_next;
    end
  end

endmodule

// File: tb/tb_drum_pad_debouncer.sv
// Randomised and directed checks of drum_pad_debouncer against a behavioural model.
module tb_drum_pad_debouncer;
  import drum_pkg::*;

  localparam int NP  = 16;
  localparam int DIV = 10;
  localparam int ST  = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [NP-1:0] pad_raw = '1;
  logic [NP-1:0] clear_mask = '0;
  logic [NP-1:0] pad_state;
  logic [NP-1:0] pad_event;
  logic          irq;

  always #5 clk = ~clk;

  drum_pad_debouncer #(
    .N_PADS(NP), .CLK_HZ(1000), .TICK_HZ(100), .STABLE_TICKS(ST), .PAD_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pad_raw(pad_raw), .clear_mask(clear_mask),
    .pad_state(pad_state), .pad_event(pad_event), .irq(irq)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a pad flips once its last ST tick samples all disagree with the
  // current level and at least ST ticks have passed since its previous flip.
  logic [NP-1:0] m_s1, m_s2, m_state, m_event, m_cmq, m_samp, m_rose, m_clr;
  logic          m_irq;
  logic [ST-1:0] m_hist [NP];
  int            m_since [NP];
  int            m_cyc;
  bit            m_tick;
  bit            model_on = 1'b0;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_s1 = '1; m_s2 = '1; m_state = '0; m_event = '0; m_cmq = '0; m_irq = 1'b0; m_cyc = 0;
      for (int p = 0; p < NP; p++) begin m_hist[p] = '0; m_since[p] = 0; end
    end else begin
      m_samp = ~m_s2;
      m_tick = ((m_cyc % DIV) == DIV - 1);
      m_rose = '0;
      if (m_tick) begin
        for (int p = 0; p < NP; p++) begin
          m_hist[p] = {m_hist[p][ST-2:0], m_samp[p]};
          m_since[p]++;
          if (m_since[p] >= ST && m_hist[p] == {ST{~m_state[p]}}) begin
            m_rose[p]  = ~m_state[p];
            m_state[p] = ~m_state[p];
            m_since[p] = 0;
          end
        end
      end
      m_clr   = clear_mask & ~m_cmq;
      m_event = m_rose | (m_event & ~m_clr);
      m_irq   = |m_event;
      m_cmq   = clear_mask;
      m_s2    = m_s1;
      m_s1    = pad_raw;
      m_cyc++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (model_on) begin
      chk("pad_state", 32'(pad_state), 32'(m_state));
      chk("pad_event", 32'(pad_event), 32'(m_event));
      chk("irq", 32'(irq), 32'(m_irq));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input int p, input logic v, input int budget, input string name,
                            output int n);
    n = 0;
    while (pad_state[p] !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(pad_state[p]), 32'(v));
  endtask

  task automatic pulse_clear(input logic [NP-1:0] m);
    clear_mask = m;
    step(1);
    clear_mask = '0;
    step(1);
  endtask

  int  n, c0, k, p;
  bit  bad;

  initial begin
    #1 reset_n = 1'b0;
    #1 model_on = 1'b1;
    step(3);
    #2 reset_n = 1'b1;

    // 1: idle after reset
    bad = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (pad_state !== '0 || pad_event !== '0 || irq !== 1'b0) bad = 1'b1;
    end
    chk("t1 idle", 32'(bad), 32'd0);

    // 2: clean press on pad 3
    @(negedge clk);
    pad_raw[3] = 1'b0;
    wait_state(3, 1'b1, 60, "t2 press", n);
    chk("t2 latency", 32'(n >= 33 && n <= 42), 32'd1);
    chk("t2 event", 32'(pad_event), 32'h0008);
    step(1);
    chk("t2 irq", 32'(irq), 32'd1);
    pulse_clear(16'h0008);
    chk("t2 cleared", 32'(pad_event), 32'h0000);

    // 3: bouncing pad 5
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      pad_raw[5] = ((i / 7) % 2 == 0) ? 1'b0 : 1'b1;
      step(1);
      if (pad_state[5] !== 1'b0) bad = 1'b1;
    end
    chk("t3 bounce", 32'(bad), 32'd0);
    pad_raw[5] = 1'b0;
    wait_state(5, 1'b1, 60, "t3 settle", n);
    chk("t3 event", 32'(pad_event), 32'h0020);
    step(30);
    chk("t3 single", 32'(pad_event), 32'h0020);
    pulse_clear(16'h0020);

    // 4: held clear mask clears only once
    pad_raw[3] = 1'b1; pad_raw[5] = 1'b1;
    wait_state(3, 1'b0, 60, "t4 rel3", n);
    wait_state(5, 1'b0, 60, "t4 rel5", n);
    pad_raw[0] = 1'b0; pad_raw[3] = 1'b0;
    wait_state(0, 1'b1, 60, "t4 press0", n);
    wait_state(3, 1'b1, 5, "t4 press3", n);
    step(1);
    chk("t4 both", 32'(pad_event), 32'h0009);
    clear_mask = 16'h0001;
    step(2);
    chk("t4 cleared", 32'(pad_event), 32'h0008);
    chk("t4 irq", 32'(irq), 32'd1);
    pad_raw[0] = 1'b1;
    wait_state(0, 1'b0, 60, "t4 rel0", n);
    pad_raw[0] = 1'b0;
    wait_state(0, 1'b1, 60, "t4 repress0", n);
    step(1);
    chk("t4 no reclear", 32'(pad_event), 32'h0009);
    clear_mask = '0;
    step(2);
    chk("t4 fall", 32'(pad_event), 32'h0009);

    // 5: press rise on the same cycle as a clear edge
    pulse_clear(16'h0001);
    pad_raw[0] = 1'b1;
    wait_state(0, 1'b0, 60, "t5 rel0", n);
    @(negedge clk);
    pad_raw[0] = 1'b0;
    c0 = m_cyc;
    k  = c0 + 2;
    while (k % DIV != DIV - 1) k++;
    k += (ST - 1) * DIV;
    while (m_cyc < k) @(negedge clk);
    chk("t5 pre", 32'(pad_state[0]), 32'd0);
    clear_mask[0] = 1'b1;
    step(1);
    chk("t5 rise", 32'(pad_state[0]), 32'd1);
    chk("t5 set wins", 32'(pad_event[0]), 32'd1);
    clear_mask = '0;

    // 6: reset in the middle of a debounce
    pad_raw = '1;
    step(60);
    pulse_clear('1);
    pad_raw[7] = 1'b0;
    step(20);
    #2 reset_n = 1'b0;
    #1 chk("t6 reset", {pad_state, pad_event, 31'(irq)} == '0 ? 32'd0 : 32'd1, 32'd0);
    step(2);
    #2 reset_n = 1'b1;
    step(39);
    chk("t6 before", 32'(pad_event), 32'h0000);
    step(1);
    chk("t6 event", 32'(pad_event), 32'h0080);
    step(1);
    chk("t6 irq", 32'(irq), 32'd1);

    // random traffic: pad flips, short glitches, clear writes
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39, 0) == 0) begin
        p = $urandom_range(NP - 1, 0);
        pad_raw[p] = ~pad_raw[p];
      end
      if ($urandom_range(19, 0) == 0) clear_mask = 16'($urandom);
      else if ($urandom_range(9, 0) == 0) clear_mask = '0;
      step(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
